// File: rtl/otbn_lsu_pipe_if.sv
// rtl/otbn_lsu_pipe_if.sv - core request, DMEM port and load response bundle of otbn_lsu_pipe
interface otbn_lsu_pipe_if #(
  parameter int AW   = 12,
  parameter int WLEN = 256,
  parameter int OW   = 2
);
  localparam int NW = WLEN / 32;

  logic            lsu_req_valid_i;
  logic            lsu_req_ready_o;
  logic            lsu_req_write_i;
  logic            lsu_req_wide_i;
  logic [AW-1:0]   lsu_addr_i;
  logic [31:0]     lsu_base_wdata_i;
  logic [WLEN-1:0] lsu_wide_wdata_i;
  logic            dmem_req_o;
  logic            dmem_gnt_i;
  logic            dmem_write_o;
  logic [AW-1:0]   dmem_addr_o;
  logic [WLEN-1:0] dmem_wdata_o;
  logic [NW-1:0]   dmem_wmask_o;
  logic [WLEN-1:0] dmem_rdata_i;
  logic            dmem_rvalid_i;
  logic            dmem_rerror_i;
  logic            lsu_rsp_valid_o;
  logic            lsu_rsp_wide_o;
  logic [31:0]     lsu_base_rdata_o;
  logic [WLEN-1:0] lsu_wide_rdata_o;
  logic            lsu_rsp_err_o;
  logic            lsu_misalign_o;
  logic [OW-1:0]   lsu_outstanding_o;
  logic            lsu_protocol_err_o;

  modport master (
    output lsu_req_valid_i, lsu_req_write_i, lsu_req_wide_i, lsu_addr_i,
           lsu_base_wdata_i, lsu_wide_wdata_i, dmem_gnt_i, dmem_rdata_i,
           dmem_rvalid_i, dmem_rerror_i,
    input  lsu_req_ready_o, dmem_req_o, dmem_write_o, dmem_addr_o, dmem_wdata_o,
           dmem_wmask_o, lsu_rsp_valid_o, lsu_rsp_wide_o, lsu_base_rdata_o,
           lsu_wide_rdata_o, lsu_rsp_err_o, lsu_misalign_o, lsu_outstanding_o,
           lsu_protocol_err_o
  );

  modport slave (
    input  lsu_req_valid_i, lsu_req_write_i, lsu_req_wide_i, lsu_addr_i,
           lsu_base_wdata_i, lsu_wide_wdata_i, dmem_gnt_i, dmem_rdata_i,
           dmem_rvalid_i, dmem_rerror_i,
    output lsu_req_ready_o, dmem_req_o, dmem_write_o, dmem_addr_o, dmem_wdata_o,
           dmem_wmask_o, lsu_rsp_valid_o, lsu_rsp_wide_o, lsu_base_rdata_o,
           lsu_wide_rdata_o, lsu_rsp_err_o, lsu_misalign_o, lsu_outstanding_o,
           lsu_protocol_err_o
  );
endinterface

// File: rtl/otbn_lsu_pipe.sv
// rtl/otbn_lsu_pipe.sv - pipelined OTBN load-store unit with in-order load tracking FIFO
// Optional response watchdog enabled by defining OTBN_LSU_RSP_WATCHDOG_EN.
module otbn_lsu_pipe #(
  parameter int DmemSizeByte   = 4096,
  parameter int WLEN           = 256,
  parameter int MaxOutstanding = 2,
  parameter int RspTimeout     = 15
) (
  input logic clk_i,
  input logic rst_i,
  otbn_lsu_pipe_if.slave bus
);
  function automatic int vbits(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  localparam int AW = vbits(DmemSizeByte);
  localparam int NW = WLEN / 32;
  localparam int WB = $clog2(WLEN / 8);
  localparam int SW = vbits(NW);
  localparam int PW = vbits(MaxOutstanding);
  localparam int OW = vbits(MaxOutstanding + 1);

  logic [MaxOutstanding-1:0] fifo_wide;
  logic [SW-1:0]             fifo_sel [MaxOutstanding];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [OW-1:0]             count;
  logic                      full, empty, push, pop;
  logic                      misalign, misalign_q, protocol_err, wd_fire;
  logic                      store_go;
  logic [SW-1:0]             word_sel, head_sel;
  logic [AW-1:0]             addr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
  endfunction

  assign addr     = bus.lsu_addr_i;
  assign full     = (count == OW'(MaxOutstanding));
  assign empty    = (count == '0);
  assign word_sel = SW'(addr[WB-1:0] >> 2);
  assign misalign = bus.lsu_req_valid_i &
                    (bus.lsu_req_wide_i ? (addr[WB-1:0] != '0) : (addr[1:0] != 2'b00));

  // Full is taken from the registered count so a pop never frees a slot for a same-cycle push.
  assign bus.dmem_req_o      = bus.lsu_req_valid_i & ~misalign & (bus.lsu_req_write_i | ~full);
  assign bus.lsu_req_ready_o = misalign | (bus.dmem_req_o & bus.dmem_gnt_i);
  assign bus.dmem_write_o    = bus.dmem_req_o & bus.lsu_req_write_i;
  assign bus.dmem_addr_o     = bus.lsu_req_valid_i ? addr : '0;
  assign store_go            = bus.dmem_write_o;
  assign bus.dmem_wdata_o    = !store_go         ? '0 :
                               bus.lsu_req_wide_i ? bus.lsu_wide_wdata_i :
                                                    {NW{bus.lsu_base_wdata_i}};
  assign bus.dmem_wmask_o    = !store_go         ? '0 :
                               bus.lsu_req_wide_i ? {NW{1'b1}} : (NW'(1) << word_sel);

  assign push     = bus.dmem_req_o & ~bus.lsu_req_write_i & bus.dmem_gnt_i;
  assign pop      = bus.dmem_rvalid_i & ~empty;
  assign head_sel = fifo_sel[rd_ptr];

  assign bus.lsu_rsp_valid_o  = pop;
  assign bus.lsu_rsp_wide_o   = pop & fifo_wide[rd_ptr];
  assign bus.lsu_base_rdata_o = pop ? bus.dmem_rdata_i[head_sel*32 +: 32] : 32'h0;
  assign bus.lsu_wide_rdata_o = pop ? bus.dmem_rdata_i : '0;
  assign bus.lsu_rsp_err_o    = pop & bus.dmem_rerror_i;

  assign bus.lsu_misalign_o     = misalign_q;
  assign bus.lsu_outstanding_o  = count;
  assign bus.lsu_protocol_err_o = protocol_err;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_wide[wr_ptr] <= bus.lsu_req_wide_i;
      fifo_sel[wr_ptr]  <= word_sel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_q   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + OW'(1);
      else if (pop && !push) count <= count - OW'(1);
      misalign_q   <= misalign;
      protocol_err <= protocol_err | (bus.dmem_rvalid_i & empty) | wd_fire;
    end
  end

`ifdef OTBN_LSU_RSP_WATCHDOG_EN
  localparam int TW = vbits(RspTimeout + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_inc;

  // The error is raised on the same edge the counter lands on RspTimeout.
  assign wd_inc  = ~empty & ~bus.dmem_rvalid_i & (wd_cnt != TW'(RspTimeout));
  assign wd_fire = wd_inc & (wd_cnt == TW'(RspTimeout - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             wd_cnt <= '0;
    else if (empty || pop) wd_cnt <= '0;
    else if (wd_inc)       wd_cnt <= wd_cnt + TW'(1);
  end
`else
  assign wd_fire = 1'b0;
`endif
endmodule

// File: tb/tb_otbn_lsu_pipe.sv
// tb/tb_otbn_lsu_pipe.sv - table-driven and scoreboard bench for otbn_lsu_pipe
module tb_otbn_lsu_pipe;
  localparam int AW = 12;
  localparam int WLEN = 256;
  localparam int OW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  otbn_lsu_pipe_if #(.AW(AW), .WLEN(WLEN), .OW(OW)) bus ();

  otbn_lsu_pipe #(
    .DmemSizeByte(4096), .WLEN(WLEN), .MaxOutstanding(2), .RspTimeout(15)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic        write;
    logic        wide;
    logic [11:0] addr;
    logic [31:0] bwd;
    logic        gnt;
    logic        exp_req;
    logic        exp_ready;
    logic [7:0]  exp_wmask;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic       wide;
    logic [2:0] sel;
  } exp_t;

  vec_t vt[10];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_w();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.lsu_req_valid_i  = 1'b0;
    bus.lsu_req_write_i  = 1'b0;
    bus.lsu_req_wide_i   = 1'b0;
    bus.lsu_addr_i       = '0;
    bus.lsu_base_wdata_i = '0;
    bus.lsu_wide_wdata_i = '0;
    bus.dmem_gnt_i       = 1'b0;
    bus.dmem_rdata_i     = '0;
    bus.dmem_rvalid_i    = 1'b0;
    bus.dmem_rerror_i    = 1'b0;
  endtask

  task automatic drive_req(input logic write, input logic wide, input logic [11:0] addr,
                           input logic [31:0] bwd, input logic [255:0] wwd, input logic gnt);
    bus.lsu_req_valid_i  = 1'b1;
    bus.lsu_req_write_i  = write;
    bus.lsu_req_wide_i   = wide;
    bus.lsu_addr_i       = addr;
    bus.lsu_base_wdata_i = bwd;
    bus.lsu_wide_wdata_i = wwd;
    bus.dmem_gnt_i       = gnt;
  endtask

  task automatic drive_rsp(input logic [255:0] rd, input logic er);
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = rd;
    bus.dmem_rerror_i = er;
  endtask

  task automatic clear_rsp();
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = '0;
    bus.dmem_rerror_i = 1'b0;
  endtask

  task automatic chk_rsp(input logic [255:0] rd, input logic er);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_underflow: got response valid %0b expected a queued load", bus.lsu_rsp_valid_o);
      return;
    end
    n_vec--;
    e = sb.pop_front();
    chk("rsp_valid", bus.lsu_rsp_valid_o, 1'b1);
    chk("rsp_wide", bus.lsu_rsp_wide_o, e.wide);
    chk("rsp_base", bus.lsu_base_rdata_o, rd[e.sel*32 +: 32]);
    chk("rsp_wdata", bus.lsu_wide_rdata_o, rd);
    chk("rsp_err", bus.lsu_rsp_err_o, er);
  endtask

  initial begin
    logic [255:0] wwd, rd, exp_wd;
    logic         acc_load;
    vec_t         v;

    vt[0] = '{1'b1, 1'b0, 12'h008, 32'h12345678, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0};
    vt[1] = '{1'b1, 1'b0, 12'h01C, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0};
    vt[2] = '{1'b1, 1'b1, 12'h020, 32'h0,        1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
    vt[3] = '{1'b0, 1'b0, 12'h024, 32'h0,        1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vt[4] = '{1'b0, 1'b1, 12'h010, 32'h0,        1'b1, 1'b0, 1'b1, 8'h00, 1'b1};
    vt[5] = '{1'b0, 1'b0, 12'h002, 32'h0,        1'b1, 1'b0, 1'b1, 8'h00, 1'b1};
    vt[6] = '{1'b0, 1'b1, 12'h040, 32'h0,        1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[7] = '{1'b1, 1'b0, 12'h003, 32'h11111111, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1};
    vt[8] = '{1'b0, 1'b1, 12'h0E0, 32'h0,        1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vt[9] = '{1'b1, 1'b1, 12'h018, 32'h0,        1'b1, 1'b0, 1'b1, 8'h00, 1'b1};

    idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_outstanding", bus.lsu_outstanding_o, 2'd0);
    chk("rst_misalign", bus.lsu_misalign_o, 1'b0);
    chk("rst_perr", bus.lsu_protocol_err_o, 1'b0);
    chk("rst_rsp_valid", bus.lsu_rsp_valid_o, 1'b0);
    chk("rst_dmem_req", bus.dmem_req_o, 1'b0);
    chk("rst_ready", bus.lsu_req_ready_o, 1'b0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      v   = vt[i];
      wwd = rand_w();
      drive_req(v.write, v.wide, v.addr, v.bwd, wwd, v.gnt);
      #1;
      chk("vec_req", bus.dmem_req_o, v.exp_req);
      chk("vec_ready", bus.lsu_req_ready_o, v.exp_ready);
      chk("vec_write", bus.dmem_write_o, v.exp_req & v.write);
      if (v.exp_req) chk("vec_addr", bus.dmem_addr_o, v.addr);
      if (v.exp_req && v.write) begin
        exp_wd = v.wide ? wwd : {8{v.bwd}};
        chk("vec_wmask", bus.dmem_wmask_o, v.exp_wmask);
        chk("vec_wdata", bus.dmem_wdata_o, exp_wd);
      end
      acc_load = v.exp_req & v.exp_ready & ~v.write;
      if (acc_load) sb.push_back('{v.wide, v.addr[4:2]});
      tick();
      idle();
      #1;
      chk("vec_misalign", bus.lsu_misalign_o, v.exp_mis);
      chk("vec_outstanding", bus.lsu_outstanding_o, {1'b0, acc_load});
      if (acc_load) begin
        rd = rand_w();
        if (i == 3) rd[63:32] = 32'hDEADBEEF;
        drive_rsp(rd, i[0]);
        #1;
        if (i == 3) chk("deadbeef", bus.lsu_base_rdata_o, 32'hDEADBEEF);
        chk_rsp(rd, i[0]);
        tick();
        clear_rsp();
        #1;
        chk("vec_drain", bus.lsu_outstanding_o, 2'd0);
      end
      tick();
      chk("vec_pulse_gone", bus.lsu_misalign_o, 1'b0);
    end

    // Two loads fill the FIFO; a third stalls until the first response frees a slot.
    drive_req(1'b0, 1'b0, 12'h004, 32'h0, '0, 1'b1);
    #1;
    chk("b2b_ready0", bus.lsu_req_ready_o, 1'b1);
    sb.push_back('{1'b0, 3'd1});
    tick();
    drive_req(1'b0, 1'b1, 12'h020, 32'h0, '0, 1'b1);
    #1;
    chk("b2b_ready1", bus.lsu_req_ready_o, 1'b1);
    sb.push_back('{1'b1, 3'd0});
    tick();
    chk("b2b_full", bus.lsu_outstanding_o, 2'd2);
    drive_req(1'b0, 1'b0, 12'h008, 32'h0, '0, 1'b1);
    #1;
    chk("b2b_stall_ready", bus.lsu_req_ready_o, 1'b0);
    chk("b2b_stall_req", bus.dmem_req_o, 1'b0);
    tick();
    rd = rand_w();
    drive_rsp(rd, 1'b0);
    #1;
    chk("b2b_pop_no_push", bus.lsu_req_ready_o, 1'b0);
    chk_rsp(rd, 1'b0);
    tick();
    chk("b2b_after_pop", bus.lsu_outstanding_o, 2'd1);
    rd = rand_w();
    drive_rsp(rd, 1'b1);
    #1;
    chk("b2b_ready2", bus.lsu_req_ready_o, 1'b1);
    sb.push_back('{1'b0, 3'd2});
    chk_rsp(rd, 1'b1);
    tick();
    chk("b2b_push_pop", bus.lsu_outstanding_o, 2'd1);
    idle();
    rd = rand_w();
    drive_rsp(rd, 1'b0);
    #1;
    chk_rsp(rd, 1'b0);
    tick();
    clear_rsp();
    chk("b2b_empty", bus.lsu_outstanding_o, 2'd0);
    chk("b2b_no_perr", bus.lsu_protocol_err_o, 1'b0);

    // Unexpected rvalid is sticky until reset; reset drops an outstanding load.
    drive_rsp(rand_w(), 1'b0);
    #1;
    chk("perr_no_rsp", bus.lsu_rsp_valid_o, 1'b0);
    tick();
    clear_rsp();
    chk("perr_set", bus.lsu_protocol_err_o, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    chk("perr_sticky", bus.lsu_protocol_err_o, 1'b1);
    drive_req(1'b0, 1'b0, 12'h00C, 32'h0, '0, 1'b1);
    tick();
    idle();
    chk("rst_mid_pre", bus.lsu_outstanding_o, 2'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_async", bus.lsu_outstanding_o, 2'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    chk("rst_mid_perr", bus.lsu_protocol_err_o, 1'b0);
    drive_rsp(rand_w(), 1'b0);
    #1;
    chk("rst_stale_rsp", bus.lsu_rsp_valid_o, 1'b0);
    tick();
    clear_rsp();
    chk("rst_stale_perr", bus.lsu_protocol_err_o, 1'b1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_req(1'b0, 1'b0, 12'h000, 32'h0, '0, 1'b1);
    sb.push_back('{1'b0, 3'd0});
    tick();
    idle();
    for (int k = 0; k < 14; k++) tick();
    chk("wd_before", bus.lsu_protocol_err_o, 1'b0);
    tick();
`ifdef OTBN_LSU_RSP_WATCHDOG_EN
    chk("wd_fire", bus.lsu_protocol_err_o, 1'b1);
`else
    chk("wd_absent", bus.lsu_protocol_err_o, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    chk("wd_absent_late", bus.lsu_protocol_err_o, 1'b0);
`endif
    chk("wd_fifo_kept", bus.lsu_outstanding_o, 2'd1);
    rd = rand_w();
    drive_rsp(rd, 1'b0);
    #1;
    chk_rsp(rd, 1'b0);
    tick();
    clear_rsp();
    chk("wd_drain", bus.lsu_outstanding_o, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/otbn_lsu_pipe.md
# otbn_lsu_pipe

Pipelined OTBN load-store unit. It sits between the OTBN core's base and bignum datapaths and a DMEM port that uses a grant and a variable-latency, in-order response. It tracks up to `MaxOutstanding` loads in a FIFO, steers each response to the base (32-bit) or wide (WLEN) read path, rejects misaligned accesses, and flags DMEM protocol violations.

## Interface
- `DmemSizeByte`, default 4096: DMEM size in bytes; `AW = vbits(DmemSizeByte)`.
- `WLEN`, default 256: wide word width in bits; `NW = WLEN/32` base words per wide word.
- `MaxOutstanding`, default 2: load-tracking FIFO depth (≥1).
- `RspTimeout`, default 15: cycles a head load may wait for `rvalid` (used only with the watchdog macro).

Ports (`name  direction  width  meaning`):
- `clk_i  in  1  clock`
- `rst_i  in  1  reset, asynchronous, active-high`
- `lsu_req_valid_i  in  1  core request valid`
- `lsu_req_ready_o  out  1  request accepted this cycle when high together with valid`
- `lsu_req_write_i  in  1  1 = store, 0 = load`
- `lsu_req_wide_i  in  1  1 = WLEN access, 0 = 32-bit access`
- `lsu_addr_i  in  AW  byte address`
- `lsu_base_wdata_i  in  32  base store data`
- `lsu_wide_wdata_i  in  WLEN  wide store data`
- `dmem_req_o  out  1  DMEM request`
- `dmem_gnt_i  in  1  DMEM grant`
- `dmem_write_o  out  1  DMEM write`
- `dmem_addr_o  out  AW  DMEM address (equals lsu_addr_i)`
- `dmem_wdata_o  out  WLEN  DMEM write data`
- `dmem_wmask_o  out  NW  per-32-bit-word write enable`
- `dmem_rdata_i  in  WLEN  DMEM read data`
- `dmem_rvalid_i  in  1  DMEM read data valid`
- `dmem_rerror_i  in  1  DMEM read error, qualified by rvalid`
- `lsu_rsp_valid_o  out  1  load response valid`
- `lsu_rsp_wide_o  out  1  response belongs to a wide load`
- `lsu_base_rdata_o  out  32  selected base word`
- `lsu_wide_rdata_o  out  WLEN  full read data`
- `lsu_rsp_err_o  out  1  response carries a DMEM error`
- `lsu_misalign_o  out  1  one-cycle pulse, cycle after a misaligned request is accepted`
- `lsu_outstanding_o  out  vbits(MaxOutstanding+1)  FIFO occupancy`
- `lsu_protocol_err_o  out  1  sticky DMEM protocol error`

## Operation
**Alignment**
- A base request is misaligned if `addr[1:0] != 0`.
- A wide request is misaligned if `addr[log2(WLEN/8)-1:0] != 0`.
- A misaligned request is accepted immediately: ready = 1, `dmem_req_o` = 0. It produces no FIFO entry and causes a `lsu_misalign_o` pulse in the next cycle.

**Aligned requests**
- Store: `dmem_req_o = valid`, ready = `dmem_gnt_i`.
- Load: `dmem_req_o = valid & ~full`, ready = `dmem_gnt_i & ~full`.
- Full is evaluated on the registered occupancy; a same-cycle pop does not free a slot for a same-cycle push.

**Store data and mask**
- Base store: wdata = `{NW{base_wdata}}`; wmask is one-hot at word `addr[log2(WLEN/8)-1:2]`.
- Wide store: wdata = `wide_wdata`; wmask = all ones.

**Load tracking**
- An accepted aligned load pushes `{wide, word_sel}` into the FIFO.
- `dmem_rvalid_i` with a non-empty FIFO pops the head. In that cycle:
  - `lsu_rsp_valid_o` = 1
  - `lsu_rsp_wide_o` = head.wide
  - `lsu_base_rdata_o` = `rdata[head.word_sel*32 +: 32]`
  - `lsu_wide_rdata_o` = `rdata`
  - `lsu_rsp_err_o` = `dmem_rerror_i`
- `dmem_rvalid_i` with an empty FIFO sets `lsu_protocol_err_o` and produces no response.
- Push and pop in the same cycle leave occupancy unchanged.

## Timing
- Request path (ready, `dmem_req_o`, wdata, wmask) is combinational from inputs and FIFO state.
- Response path is combinational from `dmem_rvalid_i` / `dmem_rdata_i`; there is zero added latency.
- The FIFO pointer/occupancy and the misalign pulse are registered.
- Reset values:
  - FIFO empty, `lsu_outstanding_o` = 0.
  - `lsu_misalign_o` = 0, `lsu_protocol_err_o` = 0, watchdog counter = 0.
  - All combinational outputs are 0 while `lsu_req_valid_i` = 0 and `dmem_rvalid_i` = 0.
- Reset asserted mid-operation discards all outstanding loads. Any `rvalid` after reset release with an empty FIFO flags a protocol error.
- `lsu_protocol_err_o` clears only on reset.

## Configuration
- `OTBN_LSU_RSP_WATCHDOG_EN` defined:
  - A counter runs while the FIFO is non-empty and `dmem_rvalid_i` = 0. It clears on every pop and whenever the FIFO is empty.
  - When the counter reaches `RspTimeout`, `lsu_protocol_err_o` sets and the counter saturates. The FIFO is not modified.
- Macro undefined: no counter is built; only unexpected `rvalid` sets `lsu_protocol_err_o`.

## Test plan
- Base load to addr 0x24 (WLEN=256), gnt=1, `rvalid` 1 cycle later with rdata word1 = 0xDEADBEEF -> rsp_valid = 1, wide = 0, base_rdata = 0xDEADBEEF, outstanding 1 → 0.
- Base store data 0x12345678 to addr 0x08 -> dmem_req = 1, write = 1, wmask = 8'b0000_0100, wdata = replicated word; no FIFO push.
- Two loads back-to-back (base at 0x04, wide at 0x20) with MaxOutstanding = 2 -> a third load sees ready = 0 until the first `rvalid`. Responses return in order with wide = 0, then wide = 1.
- Wide load to 0x10 -> ready = 1, dmem_req = 0, misalign pulse next cycle, outstanding stays 0.
- `rvalid` with empty FIFO -> protocol_err = 1 and stays 1 until `rst_i`.
- With watchdog enabled: load issued, no `rvalid` for 15 cycles -> protocol_err sets on the 15th cycle. Without the macro, protocol_err stays 0.
